column_tap_gen: RTL and testbench

- Producer side of the 5-input minimum stage in the dark-channel path.
- Converts a raster stream of 10-bit pixels into five vertically aligned taps, one per row.
- Five consecutive image rows at the same column are presented each cycle, together with an enable strobe, so the downstream minimum finder can reduce one column of a 5-row window per cycle.
- Internally holds four line buffers and tracks frame, row and column position.

---
 rtl/column_tap_gen.sv | 168 ++++++++++++++++
 tb/tb_column_tap_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/column_tap_gen.sv
// -----------------------------------------------------------------------------
// column_tap_gen
//   Producer side of the 5-input minimum stage in the dark-channel path.
//   Turns a raster stream of pixels into five vertically aligned taps (rows
//   row-4 .. row at the same column) so the downstream minimum finder can
//   reduce one column of a 5-row window per cycle.
//
// Ports
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   pixel_in     in   incoming pixel, raster order
//   pixel_valid  in   pixel_in valid this cycle
//   frame_start  in   first pixel of a frame (only with pixel_valid=1)
//   tap1..tap5   out  pixels at (row-4..row, col); tap5 is the current input
//   tap_enable   out  taps form a complete 5-row column this cycle
//   tap_row      out  row of tap5
//   tap_col      out  column of the taps
//   frame_done   out  one-cycle pulse with the last pixel of the frame
// -----------------------------------------------------------------------------
module column_tap_gen #(
  parameter int DATA_W     = 10,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [DATA_W-1:0]             pixel_in,
  input  logic                          pixel_valid,
  input  logic                          frame_start,
  output logic [DATA_W-1:0]             tap1,
  output logic [DATA_W-1:0]             tap2,
  output logic [DATA_W-1:0]             tap3,
  output logic [DATA_W-1:0]             tap4,
  output logic [DATA_W-1:0]             tap5,
  output logic                          tap_enable,
  output logic [$clog2(IMG_HEIGHT)-1:0] tap_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  tap_col,
  output logic                          frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_FILLD = RW'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_STREAM
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;

  logic [DATA_W-1:0] r_lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] r_lb2 [IMG_WIDTH];
  logic [DATA_W-1:0] r_lb3 [IMG_WIDTH];
  logic [DATA_W-1:0] r_lb4 [IMG_WIDTH];

  logic [DATA_W-1:0] r_tap1, r_tap2, r_tap3, r_tap4, r_tap5;
  logic              r_tap_enable;
  logic [RW-1:0]     r_tap_row;
  logic [CW-1:0]     r_tap_col;
  logic              r_frame_done;

  logic              w_acc;
  logic [CW-1:0]     w_col;
  logic [RW-1:0]     w_row;
  logic              w_last_col;
  logic              w_last_px;
  logic              w_stream_px;
  logic [DATA_W-1:0] w_rd1, w_rd2, w_rd3, w_rd4;

  // A frame_start pixel is always taken as (0,0), aborting any frame in flight.
  always_comb begin
    w_acc       = pixel_valid && (frame_start || (r_state != S_IDLE));
    w_col       = frame_start ? '0 : r_col;
    w_row       = frame_start ? '0 : r_row;
    w_last_col  = (w_col == COL_LAST);
    w_last_px   = w_last_col && (w_row == ROW_LAST);
    w_stream_px = (r_state == S_STREAM) && !frame_start;
  end

  // Combinational read ahead of the clocked write gives the previous row's data.
  always_comb begin
    w_rd1 = r_lb1[w_col];
    w_rd2 = r_lb2[w_col];
    w_rd3 = r_lb3[w_col];
    w_rd4 = r_lb4[w_col];
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_acc) begin
      if (w_last_px)
        w_state_nxt = S_IDLE;
      else if (w_last_col && (w_row == ROW_FILLD))
        w_state_nxt = S_STREAM;
      else if (frame_start)
        w_state_nxt = S_FILL;
    end
  end

  // Line buffers form a vertical shift chain; contents are never reset.
  always_ff @(posedge clock) begin
    if (w_acc) begin
      r_lb1[w_col] <= w_rd2;
      r_lb2[w_col] <= w_rd3;
      r_lb3[w_col] <= w_rd4;
      r_lb4[w_col] <= pixel_in;
    end
  end

  // ---- output register stage: accepted pixel at N, taps visible at N+1 ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_tap1       <= '0;
      r_tap2       <= '0;
      r_tap3       <= '0;
      r_tap4       <= '0;
      r_tap5       <= '0;
      r_tap_enable <= 1'b0;
      r_tap_row    <= '0;
      r_tap_col    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tap_enable <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_acc) begin
        r_tap1       <= w_rd1;
        r_tap2       <= w_rd2;
        r_tap3       <= w_rd3;
        r_tap4       <= w_rd4;
        r_tap5       <= pixel_in;
        r_tap_row    <= w_row;
        r_tap_col    <= w_col;
        r_tap_enable <= w_stream_px;
        r_frame_done <= w_stream_px && w_last_px;
        if (w_last_col) begin
          r_col <= '0;
          r_row <= (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
        end else begin
          r_col <= w_col + CW'(1);
          r_row <= w_row;
        end
      end
    end
  end

  assign tap1       = r_tap1;
  assign tap2       = r_tap2;
  assign tap3       = r_tap3;
  assign tap4       = r_tap4;
  assign tap5       = r_tap5;
  assign tap_enable = r_tap_enable;
  assign tap_row    = r_tap_row;
  assign tap_col    = r_tap_col;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_column_tap_gen.sv
// -----------------------------------------------------------------------------
// tb_column_tap_gen
//   Directed bench for column_tap_gen with an 8x6 image, pixel = row*16+col.
//   Expected tap records are queued as pixels are driven and popped when the
//   registered outputs appear one cycle later.
// -----------------------------------------------------------------------------
module tb_column_tap_gen;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 10;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [DW-1:0] pixel_in;
  logic          pixel_valid;
  logic          frame_start;
  logic [DW-1:0] tap1, tap2, tap3, tap4, tap5;
  logic          tap_enable;
  logic [2:0]    tap_row;
  logic [2:0]    tap_col;
  logic          frame_done;

  always #5 clock = ~clock;

  column_tap_gen #(
    .DATA_W    (DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pixel_in   (pixel_in),
    .pixel_valid(pixel_valid),
    .frame_start(frame_start),
    .tap1       (tap1),
    .tap2       (tap2),
    .tap3       (tap3),
    .tap4       (tap4),
    .tap5       (tap5),
    .tap_enable (tap_enable),
    .tap_row    (tap_row),
    .tap_col    (tap_col),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [DW-1:0] t1, t2, t3, t4, t5;
    logic          en;
    logic          fd;
    logic [2:0]    row;
    logic [2:0]    col;
    logic          full;   // t1..t4 are defined and must be compared
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   en_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // held=1: no pixel accepted last cycle, so taps/coords hold and strobes are 0
  task automatic compare_out(input exp_t e, input bit held);
    if (tap_enable === 1'b1) en_count++;
    chk("tap5",       32'(tap5),       32'(e.t5));
    chk("tap_row",    32'(tap_row),    32'(e.row));
    chk("tap_col",    32'(tap_col),    32'(e.col));
    chk("tap_enable", 32'(tap_enable), held ? 32'd0 : 32'(e.en));
    chk("frame_done", 32'(frame_done), held ? 32'd0 : 32'(e.fd));
    if (e.full) begin
      chk("tap1", 32'(tap1), 32'(e.t1));
      chk("tap2", 32'(tap2), 32'(e.t2));
      chk("tap3", 32'(tap3), 32'(e.t3));
      chk("tap4", 32'(tap4), 32'(e.t4));
    end
  endtask

  function automatic exp_t mk(input int r, input int c);
    exp_t e;
    e      = '0;
    e.t5   = 10'(r * 16 + c);
    e.row  = 3'(r);
    e.col  = 3'(c);
    e.en   = (r >= 4);
    e.fd   = (r == H - 1) && (c == W - 1);
    e.full = e.en;
    if (e.en) begin
      e.t1 = 10'((r - 4) * 16 + c);
      e.t2 = 10'((r - 3) * 16 + c);
      e.t3 = 10'((r - 2) * 16 + c);
      e.t4 = 10'((r - 1) * 16 + c);
    end
    return e;
  endfunction

  function automatic exp_t zero_e();
    exp_t e;
    e      = '0;
    e.full = 1'b1;
    return e;
  endfunction

  task automatic cyc(input logic v, input logic fs, input logic [DW-1:0] px,
                     input bit acc, input exp_t e);
    pixel_valid = v;
    frame_start = fs;
    pixel_in    = px;
    if (acc) sb.push_back(e);
    @(posedge clock);
    #1;
    if (acc) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        last_e = sb.pop_front();
        compare_out(last_e, 1'b0);
      end
    end else begin
      compare_out(last_e, 1'b1);
    end
  endtask

  // Drives a frame in raster order, stopping before (stop_r, stop_c).
  task automatic run_frame(input bit bubbles, input int stop_r, input int stop_c);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        if (bubbles) begin
          for (int b = 0; b < 3 && $urandom_range(0, 1) == 1; b++)
            cyc(1'b0, 1'($urandom_range(0, 1)), 10'($urandom), 1'b0, last_e);
        end
        cyc(1'b1, (r == 0 && c == 0), 10'(r * 16 + c), 1'b1, mk(r, c));
      end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    pixel_in    = '0;
    last_e      = zero_e();
    repeat (2) @(posedge clock);
    #1;
    compare_out(last_e, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // IDLE: valid pixels without frame_start are dropped
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 1'b0, 10'($urandom), 1'b0, last_e);

    // full frame, no bubbles
    en_count = 0;
    run_frame(1'b0, -1, -1);
    chk("en_count_full", 32'(en_count), 32'd16);

    // same frame with random bubbles
    en_count = 0;
    run_frame(1'b1, -1, -1);
    chk("en_count_bubble", 32'(en_count), 32'd16);

    // mid-frame restart at (4,3)
    run_frame(1'b0, 4, 3);
    en_count = 0;
    run_frame(1'b0, -1, -1);
    chk("en_count_restart", 32'(en_count), 32'd16);

    // asynchronous reset at pixel (5,1)
    run_frame(1'b0, 5, 1);
    pixel_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    last_e = zero_e();
    compare_out(last_e, 1'b1);
    @(posedge clock);
    #1;
    compare_out(last_e, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 10'($urandom), 1'b0, last_e);
    en_count = 0;
    run_frame(1'b0, -1, -1);
    chk("en_count_after_reset", 32'(en_count), 32'd16);

    // back-to-back frames
    en_count = 0;
    run_frame(1'b0, -1, -1);
    run_frame(1'b0, -1, -1);
    chk("en_count_b2b", 32'(en_count), 32'd32);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
